uop_sequencer: RTL
==================

UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 The block SHALL have a single clock CLK and a synchronous, active-low reset RST (asserted when RST=0, sampled on CLK rising edge).
REQ-002 Parameter START_ADDR, default 8'h00, SHALL be the micro-PC value loaded on GO from IDLE.
REQ-003 Parameter STACK_DEPTH, default 4, SHALL be the return-stack depth (legal range 1..8).
REQ-004 Ports SHALL be (name  direction  width  meaning):
- CLK  in  1  clock
- RST  in  1  sync reset, active low
- GO  in  1  start from IDLE / resume from WAIT
- UADDR  out  8  control-store address
- UVALID  out  1  fetch request
- URDY  in  1  control store has UWORD for UADDR
- UWORD  in  24  microword
- ZFLAG  in  1  datapath zero flag
- ASEL  out  3  register-file A-bus select
- BSEL  out  3  register-file B-bus select
- DSEL  out  3  register-file write select (0 = no write)
- ALUOP  out  3  ALU operation
- BUSY  out  1  not IDLE and not HALT
- HALTED  out  1  in HALT
- ERR  out  1  sticky stack fault

Function
REQ-005 Microword fields SHALL be: [23:21] ASEL, [20:18] BSEL, [17:15] DSEL, [14:12] ALUOP, [11:9] SEQ, [8] reserved (ignored), [7:0] TARGET.
REQ-006 States SHALL be IDLE, FETCH, EXEC, WAIT, HALT.
REQ-007 IDLE: GO=1 SHALL load uPC=START_ADDR, clear the stack, and enter FETCH next cycle; GO=0 SHALL remain in IDLE.
REQ-008 FETCH: UVALID=1 and UADDR=uPC; when URDY=1 in the same cycle, UWORD SHALL be latched into IR and the state SHALL become EXEC; otherwise FETCH holds with UADDR stable.
REQ-009 EXEC lasts exactly one cycle; ASEL/BSEL/DSEL/ALUOP SHALL equal the IR fields only in EXEC and SHALL be 0 in every other state, so the register file sees at most one write per microword.
REQ-010 SEQ decode in EXEC (next uPC, next state):
- 000 NEXT: uPC+1, FETCH
- 001 JUMP: TARGET, FETCH
- 010 BRZ: TARGET if ZFLAG=1 else uPC+1, FETCH
- 011 BRNZ: TARGET if ZFLAG=0 else uPC+1, FETCH
- 100 CALL: push uPC+1, TARGET, FETCH
- 101 RET: pop, FETCH
- 110 WAIT: enter WAIT
- 111 HALT: enter HALT
REQ-011 ZFLAG SHALL be sampled in the EXEC cycle.
REQ-012 uPC+1 SHALL wrap modulo 256 (8'hFF -> 8'h00), including pushed return addresses.
REQ-013 CALL with stack full, or RET with stack empty, SHALL set ERR=1, leave the stack unchanged and enter HALT.
REQ-014 WAIT: GO=1 SHALL set uPC=uPC+1 and enter FETCH; GO=0 SHALL hold.
REQ-015 HALT SHALL be left only by reset; GO SHALL be ignored.
REQ-016 Minimum throughput SHALL be one microword per 2 cycles (FETCH with URDY=1, then EXEC).
REQ-017 GO SHALL be ignored in FETCH and EXEC.

Reset
REQ-018 While RST=0: state=IDLE, uPC=START_ADDR, IR=0, stack empty, ERR=0, and all outputs 0 (UADDR, UVALID, ASEL, BSEL, DSEL, ALUOP, BUSY, HALTED, ERR).
REQ-019 Reset asserted in any state, including mid-FETCH with an outstanding request, SHALL abandon the operation. UVALID SHALL be 0 in the cycle after RST is sampled low.

Structure
REQ-020 Package uop_pkg SHALL hold the state enum, the SEQ opcode constants and the microword field bit positions.
REQ-021 The return stack SHALL be a sub-module uop_stack (LIFO, STACK_DEPTH x 8, push/pop/full/empty).

Verification
REQ-022 Reset then GO, START_ADDR=0; store supplies word ASEL=1,BSEL=2,DSEL=3,ALUOP=5,SEQ=NEXT at addr 0 with URDY=1 -> EXEC cycle shows 1/2/3/5, then UADDR=1 with UVALID=1.
REQ-023 URDY held 0 for 3 cycles in FETCH -> UADDR stable, DSEL=0 throughout, EXEC follows the first URDY=1 cycle.
REQ-024 BRZ TARGET=8'h40 at addr 5: ZFLAG=1 -> next UADDR=8'h40; ZFLAG=0 -> next UADDR=6.
REQ-025 CALL 8'h80 at addr 8'hFF, RET at 8'h80 -> UADDR sequence FF, 80, 00. Five nested CALLs with STACK_DEPTH=4 -> ERR=1, HALTED=1, GO ignored.
REQ-026 RET with empty stack -> ERR=1, HALTED=1. WAIT at addr 3 with GO pulsed after 4 cycles -> next UADDR=4.
REQ-027 RST=0 asserted during FETCH and during EXEC -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/uop_pkg.sv
// Shared types and constants for the microcode sequencer: states, SEQ opcodes
// and the bit positions of each microword field.
package uop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [2:0] SEQ_NEXT = 3'd0;
    localparam logic [2:0] SEQ_JUMP = 3'd1;
    localparam logic [2:0] SEQ_BRZ  = 3'd2;
    localparam logic [2:0] SEQ_BRNZ = 3'd3;
    localparam logic [2:0] SEQ_CALL = 3'd4;
    localparam logic [2:0] SEQ_RET  = 3'd5;
    localparam logic [2:0] SEQ_WAIT = 3'd6;
    localparam logic [2:0] SEQ_HALT = 3'd7;

    localparam int UWORD_W   = 24;
    localparam int ASEL_LSB  = 21;
    localparam int BSEL_LSB  = 18;
    localparam int DSEL_LSB  = 15;
    localparam int ALUOP_LSB = 12;
    localparam int SEQ_LSB   = 9;
    localparam int RSVD_BIT  = 8;
    localparam int TGT_LSB   = 0;

    // Decoded instruction register; the reserved bit is dropped on capture.
    typedef struct packed {
        logic [2:0] asel;
        logic [2:0] bsel;
        logic [2:0] dsel;
        logic [2:0] aluop;
        logic [2:0] seq;
        logic [7:0] target;
    } uop_fields_t;

endpackage

// File: rtl/uop_stack.sv
// Return-address LIFO for CALL/RET; callers must not push when full or pop
// when empty (such requests are ignored here).
module uop_stack #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] top,
    output logic       full,
    output logic       empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][7:0] mem_q, mem_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        top   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q == CW'(i + 1)) top = mem_q[i];
        end
        if (clr) begin
            cnt_d = '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q == CW'(i)) mem_d[i] = din;
            end
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uop_sequencer.sv
// Microprogram sequencer: fetches 24-bit microwords, drives the register-file
// and ALU controls for one EXEC cycle each, and resolves branches/calls.
module uop_sequencer
    import uop_pkg::*;
#(
    parameter logic [7:0] START_ADDR  = 8'h00,
    parameter int         STACK_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                GO,
    output logic [7:0]          UADDR,
    output logic                UVALID,
    input  logic                URDY,
    input  logic [UWORD_W-1:0]  UWORD,
    input  logic                ZFLAG,
    output logic [2:0]          ASEL,
    output logic [2:0]          BSEL,
    output logic [2:0]          DSEL,
    output logic [2:0]          ALUOP,
    output logic                BUSY,
    output logic                HALTED,
    output logic                ERR
);

    state_e      state_q, state_d;
    logic [7:0]  upc_q, upc_d;
    uop_fields_t ir_q, ir_d;
    logic        err_q, err_d;

    logic        stk_clr, stk_push, stk_pop, stk_full, stk_empty;
    logic [7:0]  stk_top;
    logic [7:0]  upc_inc;
    logic        rsvd_unused;

    assign upc_inc     = upc_q + 8'd1;
    assign rsvd_unused = UWORD[RSVD_BIT];

    uop_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (stk_clr),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (upc_inc),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        upc_d    = upc_q;
        ir_d     = ir_q;
        err_d    = err_q;
        stk_clr  = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (GO) begin
                    upc_d   = START_ADDR;
                    stk_clr = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (URDY) begin
                    ir_d.asel   = UWORD[ASEL_LSB  +: 3];
                    ir_d.bsel   = UWORD[BSEL_LSB  +: 3];
                    ir_d.dsel   = UWORD[DSEL_LSB  +: 3];
                    ir_d.aluop  = UWORD[ALUOP_LSB +: 3];
                    ir_d.seq    = UWORD[SEQ_LSB   +: 3];
                    ir_d.target = UWORD[TGT_LSB   +: 8];
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (ir_q.seq)
                    SEQ_NEXT: upc_d = upc_inc;
                    SEQ_JUMP: upc_d = ir_q.target;
                    SEQ_BRZ:  upc_d = ZFLAG ? ir_q.target : upc_inc;
                    SEQ_BRNZ: upc_d = ZFLAG ? upc_inc : ir_q.target;
                    SEQ_CALL: begin
                        // A fault leaves the stack and uPC untouched for post-mortem.
                        if (stk_full) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            stk_push = 1'b1;
                            upc_d    = ir_q.target;
                        end
                    end
                    SEQ_RET: begin
                        if (stk_empty) begin
                            err_d   = 1'b1;
                            state_d = ST_HALT;
                        end else begin
                            stk_pop = 1'b1;
                            upc_d   = stk_top;
                        end
                    end
                    SEQ_WAIT: state_d = ST_WAIT;
                    default:  state_d = ST_HALT;
                endcase
            end
            ST_WAIT: begin
                if (GO) begin
                    upc_d   = upc_inc;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            upc_q   <= START_ADDR;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    // Outputs are forced low while RST is held, not just after the reset edge.
    always_comb begin
        UADDR  = '0;
        UVALID = 1'b0;
        ASEL   = '0;
        BSEL   = '0;
        DSEL   = '0;
        ALUOP  = '0;
        BUSY   = 1'b0;
        HALTED = 1'b0;
        ERR    = 1'b0;
        if (RST) begin
            ERR    = err_q;
            HALTED = (state_q == ST_HALT);
            BUSY   = (state_q != ST_IDLE) && (state_q != ST_HALT);
            case (state_q)
                ST_FETCH: begin
                    UADDR  = upc_q;
                    UVALID = 1'b1;
                end
                ST_EXEC: begin
                    ASEL  = ir_q.asel;
                    BSEL  = ir_q.bsel;
                    DSEL  = ir_q.dsel;
                    ALUOP = ir_q.aluop;
                end
                default: ;
            endcase
        end
    end

endmodule
